// File: rtl/mux_nin_pipe_pkg.sv
// Shared encodings and helpers for the N-input registered select stage.
package mux_nin_pipe_pkg;

  localparam logic [1:0] STATE_EMPTY = 2'd0;
  localparam logic [1:0] STATE_ONE   = 2'd1;
  localparam logic [1:0] STATE_TWO   = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = STATE_EMPTY,
    ST_ONE   = STATE_ONE,
    ST_TWO   = STATE_TWO
  } state_e;

  // Select width never drops below one bit, even for a degenerate single input.
  function automatic int clog2_floor1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nin_pipe_if.sv
// Upstream/downstream handshake bundle of the select stage.
// Handshake: a beat moves on a side when valid & ready are both high at a rising
// clock edge; valid, once raised, holds its beat until that edge.
interface mux_nin_pipe_if
  import mux_nin_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = clog2_floor1(NUM_IN)
) ();
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_err, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_err, out_valid
  );
endinterface

// File: rtl/mux_nin_pipe_skid_buf2.sv
// Two-entry skid buffer: the main entry is the output register, the skid entry
// absorbs one beat so in_ready can be registered.
module mux_nin_pipe_skid_buf2
  import mux_nin_pipe_pkg::*;
#(
  parameter int            PW      = 8,
  parameter logic [PW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [PW-1:0] in_payload,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    state_dbg
);
  state_e        state;
  logic [PW-1:0] skid;
  logic          acc;
  logic          dlv;

  assign acc       = in_valid & in_ready;
  assign dlv       = out_valid & out_ready;
  assign out_valid = (state != ST_EMPTY);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      in_ready    <= 1'b1;
      out_payload <= RST_VAL;
      skid        <= '0;
    end else if (flush) begin
      // Both entries are dropped; the output register keeps its last value.
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            out_payload <= in_payload;
            state       <= ST_ONE;
          end
          in_ready <= 1'b1;
        end
        ST_ONE: begin
          if (acc && dlv) begin
            out_payload <= in_payload;
            in_ready    <= 1'b1;
          end else if (acc) begin
            skid     <= in_payload;
            state    <= ST_TWO;
            in_ready <= 1'b0;
          end else if (dlv) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
          end
        end
        ST_TWO: begin
          if (dlv) begin
            out_payload <= skid;
            state       <= ST_ONE;
            in_ready    <= 1'b1;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> $stable(out_payload));
  a_notready_two: assert property (@(posedge clk) disable iff (!rst_n)
    !in_ready |-> state == ST_TWO);
  a_no_accept_full: assert property (@(posedge clk) disable iff (!rst_n)
    !in_ready && !out_ready && !flush |=> state == ST_TWO);

endmodule

// File: rtl/mux_nin_pipe.sv
// N-input WIDTH-bit select stage feeding a registered two-entry skid buffer,
// with out-of-range select flagging and a saturating error counter.
module mux_nin_pipe
  import mux_nin_pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 3,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  mux_nin_pipe_if.slave    bus,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state_dbg
);
  localparam int SEL_W = clog2_floor1(NUM_IN);
  localparam int PW    = WIDTH + SEL_W + 1;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [PW-1:0]    out_payload;
  logic             acc;

  // When NUM_IN fills the select space the match below always hits, so err folds to 0.
  always_comb begin
    sel_data = DEFAULT_VAL;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_data = bus.in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  mux_nin_pipe_skid_buf2 #(
    .PW      (PW),
    .RST_VAL ({DEFAULT_VAL, {SEL_W{1'b0}}, 1'b0})
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_payload  ({sel_data, bus.in_sel, sel_err}),
    .in_valid    (bus.in_valid),
    .in_ready    (bus.in_ready),
    .out_payload (out_payload),
    .out_valid   (bus.out_valid),
    .out_ready   (bus.out_ready),
    .state_dbg   (state_dbg)
  );

  assign bus.out_data = out_payload[PW-1 -: WIDTH];
  assign bus.out_sel  = out_payload[SEL_W:1];
  assign bus.out_err  = out_payload[0];
  assign acc          = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (acc && sel_err && !flush && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_nin_pipe.sv
// Bench for mux_nin_pipe: a 3-input instance with a 2-bit error counter driven
// against a queue model, plus an 8-input instance for the full select space.
module tb_mux_nin_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;
  logic [1:0] err_cnt_a;
  logic [15:0] err_cnt_b;
  logic [1:0] state_a, state_b;

  int checks = 0;
  int errors = 0;

  logic [34:0] exp_q[$];
  logic [34:0] main_m;
  int          cnt_m;

  mux_nin_pipe_if #(.WIDTH(32), .NUM_IN(3)) bus_a ();
  mux_nin_pipe_if #(.WIDTH(8),  .NUM_IN(8)) bus_b ();

  mux_nin_pipe #(.WIDTH(32), .NUM_IN(3), .DEFAULT_VAL(32'h0), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(bus_a),
    .err_cnt(err_cnt_a), .state_dbg(state_a));

  mux_nin_pipe #(.WIDTH(8), .NUM_IN(8), .DEFAULT_VAL(8'h0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b),
    .err_cnt(err_cnt_b), .state_dbg(state_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] model_sel(input logic [1:0] sel);
    logic [95:0] d;
    d = bus_a.in_data;
    if (sel < 2'd3) return {d[32*sel +: 32], sel, 1'b0};
    return {32'h0, sel, 1'b1};
  endfunction

  // One clock cycle on instance A, entered and left at a falling edge.
  task automatic cyc(input bit v, input logic [1:0] sel, input bit ordy, input bit fl,
                     output bit acc);
    logic [34:0] ent;
    bit dlv;
    bus_a.in_valid  = v;
    bus_a.in_sel    = sel;
    bus_a.out_ready = ordy;
    flush_a         = fl;
    #1;
    chk("in_ready",  64'(bus_a.in_ready),  64'(exp_q.size() < 2));
    chk("out_valid", 64'(bus_a.out_valid), 64'(exp_q.size() != 0));
    chk("payload",   64'({bus_a.out_data, bus_a.out_sel, bus_a.out_err}), 64'(main_m));
    chk("err_cnt",   64'(err_cnt_a), 64'(cnt_m));
    acc = v && (exp_q.size() < 2);
    dlv = (exp_q.size() != 0) && ordy;
    ent = model_sel(sel);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (dlv) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(ent);
        if (ent[0] && cnt_m != 3) cnt_m++;
      end
    end
    if (exp_q.size() != 0) main_m = exp_q[0];
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    bit pend;
    int beats;
    int cycles;
    bit v, r, f;
    logic [1:0] s;

    bus_a.in_data = {32'hCCCC0000, 32'hBBBB0000, 32'hAAAA0000};
    bus_a.in_sel = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_data = '0; bus_b.in_sel = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
    main_m = '0; cnt_m = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_state", 64'(state_a), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic select A, B, C back-to-back
    cyc(1, 2'd0, 1, 0, acc);
    cyc(1, 2'd1, 1, 0, acc);
    cyc(1, 2'd2, 1, 0, acc);
    cyc(0, 2'd0, 1, 0, acc);
    cyc(0, 2'd0, 1, 0, acc);

    // Out-of-range select then a valid one
    cyc(1, 2'd3, 1, 0, acc);
    cyc(1, 2'd1, 1, 0, acc);
    chk("oor_cnt", 64'(err_cnt_a), 64'd1);
    cyc(0, 2'd0, 1, 0, acc);

    // Back-pressure: X then Y stall, then release
    bus_a.in_data = {32'h33333333, 32'h22222222, 32'h11111111};
    cyc(1, 2'd0, 0, 0, acc);
    cyc(1, 2'd1, 0, 0, acc);
    chk("bp_full", 64'(bus_a.in_ready), 64'd0);
    chk("bp_hold", 64'(bus_a.out_data), 64'h11111111);
    cyc(0, 2'd0, 0, 0, acc);
    cyc(0, 2'd0, 1, 0, acc);
    chk("bp_y", 64'(bus_a.out_data), 64'h22222222);
    cyc(0, 2'd0, 1, 0, acc);
    cyc(0, 2'd0, 1, 0, acc);

    // Flush in TWO with a bad select offered, then flush in ONE with a bad select
    cyc(1, 2'd0, 0, 0, acc);
    cyc(1, 2'd2, 0, 0, acc);
    cyc(1, 2'd3, 0, 1, acc);
    cyc(1, 2'd1, 0, 0, acc);
    cyc(1, 2'd3, 0, 1, acc);
    cyc(0, 2'd0, 0, 0, acc);
    chk("flush_cnt", 64'(err_cnt_a), 64'd1);

    // Async reset while stalled with two entries
    cyc(1, 2'd0, 0, 0, acc);
    cyc(1, 2'd1, 0, 0, acc);
    bus_a.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus_a.out_valid), 64'd0);
    chk("arst_ready", 64'(bus_a.in_ready), 64'd1);
    chk("arst_cnt", 64'(err_cnt_a), 64'd0);
    chk("arst_data", 64'(bus_a.out_data), 64'd0);
    exp_q.delete(); main_m = '0; cnt_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Counter saturation at 2^2-1
    repeat (5) cyc(1, 2'd3, 1, 0, acc);
    cyc(0, 2'd0, 1, 0, acc);
    chk("sat_cnt", 64'(err_cnt_a), 64'd3);

    // Random traffic with flushes against the queue model
    beats = 0; cycles = 0; pend = 0; v = 0; s = '0;
    while (beats < 10000 && cycles < 40000) begin
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        bus_a.in_data = {$urandom, $urandom, $urandom};
      end
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 49) == 0);
      cyc(v, s, r, f, acc);
      pend = v && !acc && !f;
      if (acc && !f) beats++;
      cycles++;
    end
    chk("rand_beats", 64'(beats >= 10000), 64'd1);
    cyc(0, 2'd0, 1, 0, acc);
    cyc(0, 2'd0, 1, 0, acc);
    cyc(0, 2'd0, 1, 0, acc);

    // Full select space: input 7 of 8
    for (int k = 0; k < 8; k++) bus_b.in_data[8*k +: 8] = 8'(8'h10 + k);
    bus_b.in_sel = 3'd7;
    bus_b.in_valid = 1'b1;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    #1;
    chk("b_valid", 64'(bus_b.out_valid), 64'd1);
    chk("b_data", 64'(bus_b.out_data), 64'h17);
    chk("b_sel", 64'(bus_b.out_sel), 64'd7);
    chk("b_err", 64'(bus_b.out_err), 64'd0);
    chk("b_cnt", 64'(err_cnt_b), 64'd0);
    @(negedge clk);
    #1;
    chk("b_drain", 64'(bus_b.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
